soc_bus_master: RTL and testbench

//  Initiator side of the SoC memory bus: turns single-word commands from a host (debug bridge / loader)

---
 rtl/registers_pkg.sv | 11 +
 rtl/soc_bus_master_pkg.sv | 18 +
 rtl/SoC_MemBus.sv | 12 +
 rtl/soc_bus_wait_counter.sv | 30 +++
 rtl/soc_bus_master.sv | 117 +++++++++++
 tb/tb_soc_bus_master.sv | 347 ++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/registers_pkg.sv
// Register access types shared by every register-file slave and bus master.
package registers_pkg;

  typedef enum logic [1:0] {
    REG_MAIN   = 2'd0,
    REG_SET    = 2'd1,
    REG_CLEAR  = 2'd2,
    REG_TOGGLE = 2'd3
  } reg_access_t;

endpackage

// File: rtl/soc_bus_master_pkg.sv
// Types and constants for the SoC memory bus master.
package soc_bus_master_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} busmst_state_t;

  localparam int ADDR_TYPE_LSB = 2;
  localparam int WAIT_CNT_W    = 8;

  // Places an access type into the address bits that slaves decode it from.
  function automatic logic [31:0] with_access(input logic [31:0] reg_addr,
                                              input registers_pkg::reg_access_t acc);
    logic [31:0] a;
    a = reg_addr;
    a[ADDR_TYPE_LSB +: 2] = acc;
    return a;
  endfunction

endpackage

// File: rtl/SoC_MemBus.sv
// SoC memory bus: one-cycle request from the master, slave signals completion with ack (rdata valid with ack).
interface SoC_MemBus;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport Master (output req, we, addr, wdata, input ack, rdata);
  modport Slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/soc_bus_wait_counter.sv
// Saturating WAIT-state cycle counter; flags when the slave may be sampled and when the wait has expired.
module soc_bus_wait_counter
  import soc_bus_master_pkg::*;
#(
  parameter int BUS_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic res,
  input  logic clr,
  input  logic en,
  output logic lat_ok,
  output logic timeout
);

  logic [WAIT_CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (res || clr) begin
      count_q <= '0;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + WAIT_CNT_W'(1);
    end
  end

  // count_q holds the number of WAIT cycles already completed before the current one
  assign lat_ok  = int'(count_q) >= (BUS_LATENCY - 1);
  assign timeout = int'(count_q) >= (TIMEOUT_CYCLES - 1);

endmodule

// File: rtl/soc_bus_master.sv
// Host-command to SoC_MemBus initiator, one transaction at a time.
// Optional abort of a stalled WAIT: define SOC_BUS_MASTER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a host command
// REQ   | bus request driven for one cycle from captured command
// WAIT  | waiting for slave completion (or timeout)
// RESP  | response held to the host until rsp_ready
module soc_bus_master
  import soc_bus_master_pkg::*;
#(
  parameter int BUS_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             res,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             busy,
  SoC_MemBus.Master        mem_bus
);

`ifdef SOC_BUS_MASTER_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  busmst_state_t state_q, state_d;
  logic          complete, expire;
  logic          lat_ok, timeout;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic          err_q;

  soc_bus_wait_counter #(
    .BUS_LATENCY    (BUS_LATENCY),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_cnt (
    .clk     (clk),
    .res     (res),
    .clr     (state_q != WAIT),
    .en      (state_q == WAIT),
    .lat_ok  (lat_ok),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    expire   = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        complete = mem_bus.ack && lat_ok;
        // a completion in the same cycle as the timeout takes priority
        expire   = TIMEOUT_EN && timeout && !complete;
        if (complete || expire) state_d = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((state_q == IDLE) && cmd_valid) begin
        we_q    <= cmd_we;
        addr_q  <= cmd_addr & ~32'h3;
        wdata_q <= cmd_wdata;
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
      if (complete) begin
        rdata_q <= we_q ? 32'h0 : mem_bus.rdata;
        err_q   <= 1'b0;
      end else if (expire) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign mem_bus.req   = (state_q == REQ);
  assign mem_bus.we    = we_q;
  assign mem_bus.addr  = addr_q;
  assign mem_bus.wdata = wdata_q;

endmodule

// File: tb/tb_soc_bus_master.sv
// Self-checking bench for soc_bus_master: vector table plus multi-cycle corner sequences.
module tb_soc_bus_master;
  import soc_bus_master_pkg::*;
  import registers_pkg::*;

  localparam int          BUS_LATENCY    = 2;
  localparam int          TIMEOUT_CYCLES = 16;
  localparam logic [31:0] CONTROL = 32'h4000_0000;
  localparam logic [31:0] INT_EN  = 32'h4000_0010;
  localparam logic [31:0] STATUS  = 32'h4000_0020;
  localparam logic [31:0] SCRATCH = 32'h4000_0030;

  logic        clk, res;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;

  SoC_MemBus bus();

  soc_bus_master #(
    .BUS_LATENCY    (BUS_LATENCY),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .res       (res),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .mem_bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave model: completes slv_delay cycles after the request, holds ack until the next request
  logic [31:0] slv_mem [256];
  logic        slv_pend;
  int          slv_cnt;
  logic [7:0]  slv_idx;
  int          slv_delay;
  bit          slv_mute;

  always @(posedge clk) begin
    if (res) begin
      slv_pend <= 1'b0;
      slv_cnt  <= 0;
    end else if (bus.req) begin
      slv_pend <= 1'b1;
      slv_cnt  <= slv_delay;
      slv_idx  <= bus.addr[9:2];
      if (bus.we) slv_mem[bus.addr[9:2]] <= bus.wdata;
    end else if (slv_pend && (slv_cnt > 0)) begin
      slv_cnt <= slv_cnt - 1;
    end
  end

  assign bus.ack   = slv_pend && (slv_cnt == 0) && !slv_mute;
  assign bus.rdata = bus.ack ? slv_mem[slv_idx] : 32'hDEAD_BEEF;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_op_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          delay;
  } vec_t;

  bus_op_t  bus_q[$];
  rsp_exp_t rsp_q[$];
  bus_op_t  cur_op;
  bit       have_cur;
  int       req_count, rsp_seen;
  int       total, bad;
  vec_t     vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input int d);
    return ((3 + d) > (2 + BUS_LATENCY)) ? (3 + d) : (2 + BUS_LATENCY);
  endfunction

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      total++;
      bad++;
      $display("FAIL rsp_wait: got no rsp_valid expected one within 200 cycles");
    end
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit push_rsp, input logic [31:0] exp_rd, input logic exp_err);
    bit ok;
    bus_q.push_back('{we, addr & ~32'h3, wdata});
    if (push_rsp) rsp_q.push_back('{exp_rd, exp_err});
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL cmd_wait: got cmd_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_we    = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
  endtask

  initial begin
    int lat, rc0, rs0, last_hs, cyc, idx;
    bus_op_t b2b[3];

    total = 0; bad = 0; req_count = 0; rsp_seen = 0; have_cur = 1'b0;
    res = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; slv_delay = 0; slv_mute = 1'b0;

    vecs[0] = '{1'b1, with_access(CONTROL, REG_MAIN), 32'h0000_000F, 32'h0,         1'b0, 0};
    vecs[1] = '{1'b1, with_access(INT_EN,  REG_MAIN), 32'hA5A5_0001, 32'h0,         1'b0, 1};
    vecs[2] = '{1'b0, with_access(INT_EN,  REG_MAIN), 32'h0,         32'hA5A5_0001, 1'b0, 0};
    vecs[3] = '{1'b0, with_access(CONTROL, REG_MAIN), 32'h0,         32'h0000_000F, 1'b0, 3};
    vecs[4] = '{1'b1, with_access(STATUS,  REG_SET),  32'h1234_5678, 32'h0,         1'b0, 2};
    vecs[5] = '{1'b0, with_access(STATUS,  REG_SET),  32'h0,         32'h1234_5678, 1'b0, 5};
    vecs[6] = '{1'b1, SCRATCH | 32'h3,                32'hCAFE_0003, 32'h0,         1'b0, 0};
    vecs[7] = '{1'b0, SCRATCH,                        32'h0,         32'hCAFE_0003, 1'b0, 1};

    fork
      forever begin
        @(negedge clk);
        if (bus.req) begin
          req_count++;
          if (bus_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL bus_unexpected_req: got request addr=%h expected none", bus.addr);
          end else begin
            cur_op   = bus_q.pop_front();
            have_cur = 1'b1;
            chk("bus_we", bus.we, cur_op.we);
            chk("bus_addr", bus.addr, cur_op.addr);
            if (cur_op.we) chk("bus_wdata", bus.wdata, cur_op.wdata);
          end
        end else if (busy && !rsp_valid && have_cur) begin
          chk("bus_hold_addr", bus.addr, cur_op.addr);
          if (cur_op.we) chk("bus_hold_wdata", bus.wdata, cur_op.wdata);
        end
      end
      forever begin
        @(negedge clk);
        if (rsp_valid && rsp_ready) begin
          rsp_exp_t e;
          rsp_seen++;
          if (rsp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: got rsp rdata=%h err=%b expected none", rsp_rdata, rsp_err);
          end else begin
            e = rsp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
          end
        end
      end
    join_none

    // reset state
    repeat (3) @(posedge clk);
    #1 res = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_bus_req", bus.req, 0);

    // vector table
    for (int v = 0; v < 8; v++) begin
      slv_delay = vecs[v].delay;
      send_cmd(vecs[v].we, vecs[v].addr, vecs[v].wdata, 1'b1, vecs[v].exp_rd, vecs[v].exp_err);
      wait_rsp(lat);
      chk($sformatf("vec%0d_latency", v), lat, exp_lat(vecs[v].delay));
    end

    // response held off: stable response, new command not accepted or issued
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    slv_delay = 0;
    send_cmd(1'b0, INT_EN, 32'h0, 1'b1, 32'hA5A5_0001, 1'b0);
    wait_rsp(lat);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = SCRATCH; cmd_wdata = 32'h5555_AAAA;
    rc0 = req_count;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    chk("hold_no_bus_req", req_count - rc0, 0);
    bus_q.push_back('{1'b1, SCRATCH, 32'h5555_AAAA});
    rsp_q.push_back('{32'h0, 1'b0});
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_hs_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    chk("next_cycle_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_rsp(lat);
    chk("held_cmd_latency", lat, exp_lat(0));

    // reset during WAIT abandons the transaction
    @(posedge clk); #1;
    slv_mute = 1'b1;
    send_cmd(1'b0, CONTROL, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    chk("wait_busy", busy, 1);
    rs0 = rsp_seen;
    @(posedge clk); #1;
    res = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("res_busy", busy, 0);
    chk("res_rsp_valid", rsp_valid, 0);
    chk("res_cmd_ready", cmd_ready, 1);
    chk("res_bus_req", bus.req, 0);
    @(posedge clk); #1;
    res = 1'b0;
    slv_mute = 1'b0;
    repeat (20) @(negedge clk);
    chk("res_no_response", rsp_seen - rs0, 0);
    chk("res_idle", busy, 0);

    // slave that does not answer
    @(posedge clk); #1;
    slv_mute  = 1'b1;
    slv_delay = 0;
`ifdef SOC_BUS_MASTER_TIMEOUT_EN
    send_cmd(1'b0, CONTROL, 32'h0, 1'b1, 32'h0, 1'b1);
    wait_rsp(lat);
    chk("timeout_latency", lat, 2 + TIMEOUT_CYCLES);
    @(posedge clk); #1;
    slv_mute  = 1'b0;
    slv_delay = TIMEOUT_CYCLES - 1;
    send_cmd(1'b0, CONTROL, 32'h0, 1'b1, 32'h0000_000F, 1'b0);
    wait_rsp(lat);
    chk("late_ack_latency", lat, 2 + TIMEOUT_CYCLES);
`else
    send_cmd(1'b0, CONTROL, 32'h0, 1'b1, 32'h0000_000F, 1'b0);
    repeat (40) @(negedge clk);
    chk("no_abort_rsp_valid", rsp_valid, 0);
    chk("no_abort_busy", busy, 1);
    @(posedge clk); #1;
    slv_mute = 1'b0;
    wait_rsp(lat);
    chk("late_ack_latency", lat, 2);
`endif

    // back-to-back commands with cmd_valid held high
    @(posedge clk); #1;
    slv_mute  = 1'b0;
    slv_delay = 0;
    b2b[0] = '{1'b1, 32'h4000_0040, 32'h1111_0000};
    b2b[1] = '{1'b0, 32'h4000_0040, 32'h0};
    b2b[2] = '{1'b1, 32'h4000_0050, 32'h2222_0000};
    for (int k = 0; k < 3; k++) bus_q.push_back(b2b[k]);
    rsp_q.push_back('{32'h0, 1'b0});
    rsp_q.push_back('{32'h1111_0000, 1'b0});
    rsp_q.push_back('{32'h0, 1'b0});
    rc0 = req_count;
    cmd_valid = 1'b1; cmd_we = b2b[0].we; cmd_addr = b2b[0].addr; cmd_wdata = b2b[0].wdata;
    idx = 0; cyc = 0; last_hs = 0;
    for (int c = 0; c < 200 && idx < 3; c++) begin
      @(negedge clk);
      cyc++;
      if (cmd_ready) begin
        if (idx > 0) chk("b2b_spacing", cyc - last_hs, exp_lat(0) + 1);
        last_hs = cyc;
        idx++;
        @(posedge clk); #1;
        if (idx < 3) begin
          cmd_we = b2b[idx].we; cmd_addr = b2b[idx].addr; cmd_wdata = b2b[idx].wdata;
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    chk("b2b_accepted", idx, 3);
    wait_rsp(lat);
    @(negedge clk);
    chk("b2b_bus_requests", req_count - rc0, 3);

    repeat (3) @(negedge clk);
    chk("bus_q_drained", bus_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
